uart_mc_handler: RTL
====================

UART_MC_HANDLER -- requirements
Module: uart_mc_handler

Interface
REQ-001 Parameter NUM_CH, default 2: number of UART channels (1..8).
REQ-002 Parameter TX_DEPTH, default 16: per-channel TX FIFO depth, power of 2.
REQ-003 Parameter RX_DEPTH, default 256: per-channel RX FIFO depth, power of 2.
REQ-004 Parameter SRC_BASE, default 8'h01: upload source ID of channel 0; channel c uses SRC_BASE+c.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cmd_type  in  8  command code, valid with cmd_start.
REQ-008 cmd_data  in  8  payload byte.
REQ-009 cmd_data_index  in  16  payload byte index, 0-based.
REQ-010 cmd_start  in  1  one-cycle command start strobe.
REQ-011 cmd_data_valid  in  1  cmd_data valid.
REQ-012 cmd_done  in  1  one-cycle end-of-payload strobe.
REQ-013 cmd_ready  out  1  payload byte acceptable.
REQ-014 upload_active  out  1  high while in UPLOAD.
REQ-015 upload_req  out  1  equals upload_valid.
REQ-016 upload_data  out  8  byte being uploaded.
REQ-017 upload_source  out  8  SRC_BASE+channel being uploaded.
REQ-018 upload_valid  out  1  upload_data valid; held until accepted.
REQ-019 upload_ready  in  1  sink accepts byte when high with upload_valid.
REQ-020 uart_tx_data  out  NUM_CH*8  per-channel TX byte to UART core.
REQ-021 uart_tx_val  out  NUM_CH  per-channel TX request.
REQ-022 uart_tx_busy  in  NUM_CH  per-channel core busy.
REQ-023 uart_rx_data  in  NUM_CH*8  per-channel received byte.
REQ-024 uart_rx_val  in  NUM_CH  one-cycle received-byte strobe.
REQ-025 cfg_word  out  NUM_CH*56  per channel {baud[31:0], data_bits[7:0], stop_bits[7:0], parity[7:0]}.
REQ-026 rx_overflow  out  NUM_CH  sticky per-channel RX drop flag.

Function
REQ-027 Top FSM states: IDLE, CFG, UPD, TX, RX, UPLOAD. In IDLE, cmd_start with type 8'h07->CFG, 8'h08->TX, 8'h09->RX; any other type, and cmd_start outside IDLE, is ignored.
REQ-028 Payload byte index 0 selects channel ch; if ch>=NUM_CH, rest of command is consumed with no effect, FSM returns to IDLE on cmd_done.
REQ-029 CFG: bytes at index 1..7 are buffered; cmd_done->UPD; UPD lasts one cycle, loads cfg_word[ch] (baud big-endian from bytes 1-4, then bytes 5, 6, 7), ->IDLE; unsent bytes keep their prior buffer value.
REQ-030 TX: each byte at index>=1 with cmd_data_valid pushes into TX FIFO[ch]; cmd_done->IDLE.
REQ-031 cmd_ready = IDLE | CFG | (TX & (index-0 byte not yet received | TX FIFO[ch] not full)); bytes arriving when full are dropped.
REQ-032 Per-channel TX engine, independent: T_IDLE (FIFO non-empty: latch head byte)->T_SEND (uart_tx_val=1 until uart_tx_busy=1, then pop)->T_WAIT (until uart_tx_busy=0)->T_IDLE.
REQ-033 uart_rx_val[c] pushes uart_rx_data[c] into RX FIFO[c]; if full and no pop that cycle, byte is dropped and rx_overflow[c] set.
REQ-034 RX: on cmd_done, snapshot n=RX count[ch] and clear rx_overflow[ch] (a drop in the same cycle keeps it set); n=0->IDLE, else->UPLOAD.
REQ-035 UPLOAD: exactly n bytes are presented in FIFO order; a transfer is upload_valid&upload_ready; next byte valid the cycle after; back-to-back 1 byte/cycle sustained; after nth transfer ->IDLE next cycle; bytes received during UPLOAD stay queued.
REQ-036 Simultaneous push and pop on one FIFO: both performed, count unchanged; pointers wrap modulo depth; count width log2(depth)+1.

Reset
REQ-037 rst=1: all FSMs idle, FIFOs empty, all outputs 0 except upload_source=SRC_BASE, cfg_word per channel={115200,8,0,0}, cmd_ready=1; reset mid-upload or mid-TX discards all queued data.

Verification
REQ-038 CFG ch1 payload 01 00 01 C2 00 08 00 00 -> after cmd_done+2 cycles cfg_word[1]={0x0001C200,8,0,0}, ch0 unchanged.
REQ-039 TX ch0 payload 00 41 42 43, core busy 10 cycles per byte -> uart_tx_data[7:0] 0x41,0x42,0x43 in order, one uart_tx_val burst each.
REQ-040 RX_DEPTH+3 strobes on ch1 -> count=RX_DEPTH, rx_overflow[1]=1; RX cmd ch1 -> RX_DEPTH uploads, upload_source=SRC_BASE+1, flag cleared.
REQ-041 Snapshot 3 bytes, 2 more arrive mid-upload, upload_ready toggling -> exactly 3 uploads, 2 remain, FSM to IDLE.
REQ-042 RX cmd with channel byte 0x05 (NUM_CH=2), and RX cmd on empty channel -> no upload_valid, IDLE after cmd_done.

Source files
------------

// File: rtl/uart_mc_handler.sv
// rtl/uart_mc_handler.sv - multi-channel UART command handler with per-channel TX/RX queues
// Commands configure channels, queue TX bytes, and upload buffered RX bytes to a sink.

module uart_mc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue still lands when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end
endmodule

module uart_mc_handler #(
  parameter int         NUM_CH   = 2,
  parameter int         TX_DEPTH = 16,
  parameter int         RX_DEPTH = 256,
  parameter logic [7:0] SRC_BASE = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           cmd_type,
  input  logic [7:0]           cmd_data,
  input  logic [15:0]          cmd_data_index,
  input  logic                 cmd_start,
  input  logic                 cmd_data_valid,
  input  logic                 cmd_done,
  output logic                 cmd_ready,
  output logic                 upload_active,
  output logic                 upload_req,
  output logic [7:0]           upload_data,
  output logic [7:0]           upload_source,
  output logic                 upload_valid,
  input  logic                 upload_ready,
  output logic [NUM_CH*8-1:0]  uart_tx_data,
  output logic [NUM_CH-1:0]    uart_tx_val,
  input  logic [NUM_CH-1:0]    uart_tx_busy,
  input  logic [NUM_CH*8-1:0]  uart_rx_data,
  input  logic [NUM_CH-1:0]    uart_rx_val,
  output logic [NUM_CH*56-1:0] cfg_word,
  output logic [NUM_CH-1:0]    rx_overflow
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam logic [TCW-1:0] TX_FULL     = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL     = RCW'(RX_DEPTH);
  localparam logic [RCW-1:0] RX_ONE      = RCW'(1);
  localparam logic [7:0]     NUM_CH_B    = 8'(NUM_CH);
  localparam logic [55:0]    CFG_DEFAULT = {32'd115200, 8'd8, 8'd0, 8'd0};

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_UPD, S_TX, S_RX, S_UPLOAD} state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;

  state_t          state;
  logic [CHW-1:0]  ch;
  logic            ch_seen;
  logic            ch_ok;
  logic [7:0]      cfg_buf [8];
  logic [55:0]     cfg_q [NUM_CH];
  logic [RCW-1:0]  remaining;

  logic [7:0]      tx_head [NUM_CH];
  logic [TCW-1:0]  tx_count [NUM_CH];
  logic [7:0]      rx_head [NUM_CH];
  logic [RCW-1:0]  rx_count [NUM_CH];
  logic [NUM_CH-1:0] tx_push, tx_pop, rx_pop, rx_drop, ovf_clr;

  logic ch_sel, idx0, payload_byte, xfer, rx_done;

  assign ch_sel       = ch_seen && ch_ok;
  assign idx0         = cmd_data_valid && (cmd_data_index == 16'd0);
  assign payload_byte = cmd_data_valid && (cmd_data_index != 16'd0);
  assign rx_done      = (state == S_RX) && cmd_done;

  assign upload_valid  = (state == S_UPLOAD);
  assign upload_active = upload_valid;
  assign upload_req    = upload_valid;
  assign upload_data   = upload_valid ? rx_head[ch] : 8'd0;
  assign xfer          = upload_valid && upload_ready;

  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      S_IDLE, S_CFG: cmd_ready = 1'b1;
      S_TX:          cmd_ready = !ch_sel || (tx_count[ch] != TX_FULL);
      default:       cmd_ready = 1'b0;
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tx_state_t  tx_st;
    logic       tx_val_q;
    logic [7:0] tx_byte_q;
    logic       ch_hit;

    assign ch_hit     = ch_sel && (ch == CHW'(c));
    assign tx_push[c] = (state == S_TX) && payload_byte && ch_hit;
    assign tx_pop[c]  = (tx_st == T_SEND) && uart_tx_busy[c];
    assign rx_pop[c]  = xfer && (ch == CHW'(c));
    assign rx_drop[c] = uart_rx_val[c] && (rx_count[c] == RX_FULL) && !rx_pop[c];
    assign ovf_clr[c] = rx_done && ch_hit;

    uart_mc_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push[c]), .push_data(cmd_data),
      .pop(tx_pop[c]), .head(tx_head[c]), .count(tx_count[c])
    );

    uart_mc_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(uart_rx_val[c]), .push_data(uart_rx_data[c*8 +: 8]),
      .pop(rx_pop[c]), .head(rx_head[c]), .count(rx_count[c])
    );

    // The head byte stays queued until the core acknowledges it by raising busy.
    always_ff @(posedge clk) begin
      if (rst) begin
        tx_st     <= T_IDLE;
        tx_val_q  <= 1'b0;
        tx_byte_q <= 8'd0;
      end else begin
        case (tx_st)
          T_IDLE: if (tx_count[c] != '0) begin
            tx_byte_q <= tx_head[c];
            tx_val_q  <= 1'b1;
            tx_st     <= T_SEND;
          end
          T_SEND: if (uart_tx_busy[c]) begin
            tx_val_q <= 1'b0;
            tx_st    <= T_WAIT;
          end
          T_WAIT: if (!uart_tx_busy[c]) tx_st <= T_IDLE;
          default: tx_st <= T_IDLE;
        endcase
      end
    end

    assign uart_tx_val[c]         = tx_val_q;
    assign uart_tx_data[c*8 +: 8] = tx_byte_q;
    assign cfg_word[c*56 +: 56]   = cfg_q[c];
  end

  // A drop in the same cycle as the clear wins, so no overflow goes unreported.
  always_ff @(posedge clk) begin
    if (rst) rx_overflow <= '0;
    else     rx_overflow <= rx_drop | (rx_overflow & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ch            <= '0;
      ch_seen       <= 1'b0;
      ch_ok         <= 1'b0;
      remaining     <= '0;
      upload_source <= SRC_BASE;
      cfg_buf[0]    <= 8'd0;
      for (int i = 1; i < 8; i++) cfg_buf[i] <= CFG_DEFAULT[8*(7-i) +: 8];
      for (int c = 0; c < NUM_CH; c++) cfg_q[c] <= CFG_DEFAULT;
    end else begin
      if ((state inside {S_CFG, S_TX, S_RX}) && idx0 && !ch_seen) begin
        ch_seen <= 1'b1;
        ch_ok   <= (cmd_data < NUM_CH_B);
        ch      <= cmd_data[CHW-1:0];
      end
      case (state)
        S_IDLE: if (cmd_start) begin
          ch_seen <= 1'b0;
          ch_ok   <= 1'b0;
          case (cmd_type)
            8'h07:   state <= S_CFG;
            8'h08:   state <= S_TX;
            8'h09:   state <= S_RX;
            default: state <= S_IDLE;
          endcase
        end
        S_CFG: begin
          // The staging buffer persists, so bytes a command omits keep their last value.
          if (payload_byte && ch_sel && (cmd_data_index <= 16'd7))
            cfg_buf[cmd_data_index[2:0]] <= cmd_data;
          if (cmd_done) state <= ch_sel ? S_UPD : S_IDLE;
        end
        S_UPD: begin
          cfg_q[ch] <= {cfg_buf[1], cfg_buf[2], cfg_buf[3], cfg_buf[4],
                        cfg_buf[5], cfg_buf[6], cfg_buf[7]};
          state     <= S_IDLE;
        end
        S_TX: if (cmd_done) state <= S_IDLE;
        S_RX: if (cmd_done) begin
          if (ch_sel && (rx_count[ch] != '0)) begin
            remaining     <= rx_count[ch];
            upload_source <= SRC_BASE + 8'(ch);
            state         <= S_UPLOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_UPLOAD: if (xfer) begin
          remaining <= remaining - RX_ONE;
          if (remaining == RX_ONE) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
